// File: rtl/bru_update_arbiter.sv
// Merges the two BRU predictor-update streams into one registered port, oldest ticket first.
// Update word layout: {valid_jump, info[INFO_W-1:0], ticket[TICKET_W-1:0]}.
module bru_update_arbiter #(
  parameter int DEPTH    = 2,
  parameter int TICKET_W = 5,
  parameter int INFO_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in0_valid,
  input  logic [INFO_W+TICKET_W:0] in0_data,
  output logic                     in0_ready,
  input  logic                     in1_valid,
  input  logic [INFO_W+TICKET_W:0] in1_data,
  output logic                     in1_ready,
  input  logic [TICKET_W-1:0]      rob_head,
  input  logic                     flush_valid,
  input  logic [TICKET_W-1:0]      flush_ticket,
  input  logic                     flush_all,
  output logic                     out_valid,
  output logic [INFO_W+TICKET_W:0] out_data,
  input  logic                     out_ready
);
  localparam int UW = INFO_W + TICKET_W + 1;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [UW-1:0]       mem [2][DEPTH];
  logic [PW-1:0]       wr_ptr [2];
  logic [PW-1:0]       rd_ptr [2];
  logic [PW-1:0]       base_wr [2];
  logic                in_valid [2];
  logic [UW-1:0]       in_data [2];
  logic                full [2];
  logic                head_valid [2];
  logic [UW-1:0]       head [2];
  logic                we [2];
  logic                pop [2];
  logic                partial;
  logic                load;
  logic                pick1;
  logic                kill_out;
  logic [TICKET_W-1:0] flush_age;

  function automatic logic [TICKET_W-1:0] age_of(input logic [UW-1:0] d,
                                                 input logic [TICKET_W-1:0] origin);
    return d[TICKET_W-1:0] - origin;
  endfunction

  assign in_valid[0] = in0_valid;
  assign in_valid[1] = in1_valid;
  assign in_data[0]  = in0_data;
  assign in_data[1]  = in1_data;
  assign partial     = flush_valid & ~flush_all;
  assign flush_age   = flush_ticket - rob_head;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      full[p]       = (wr_ptr[p][AW-1:0] == rd_ptr[p][AW-1:0]) && (wr_ptr[p][AW] != rd_ptr[p][AW]);
      head_valid[p] = (wr_ptr[p] != rd_ptr[p]);
      head[p]       = mem[p][rd_ptr[p][AW-1:0]];
    end
  end

  assign in0_ready = ~full[0];
  assign in1_ready = ~full[1];

  // Killed entries are a suffix of each FIFO, so the new write pointer is rd + survivors.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      logic [PW-1:0] occ;
      logic [AW-1:0] idx;
      logic          alive;
      occ        = wr_ptr[p] - rd_ptr[p];
      base_wr[p] = rd_ptr[p];
      alive      = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        idx = rd_ptr[p][AW-1:0] + AW'(i);
        if (alive && (PW'(i) < occ) && (age_of(mem[p][idx], rob_head) <= flush_age))
          base_wr[p] = base_wr[p] + PW'(1);
        else
          alive = 1'b0;
      end
      if (!partial) base_wr[p] = wr_ptr[p];
    end
  end

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      we[p] = in_valid[p] & in_data[p][UW-1] & ~full[p] & ~flush_all &
              ~(partial && (age_of(in_data[p], rob_head) > flush_age));
    end
  end

  assign load     = ~flush_valid & ~flush_all & (~out_valid | out_ready);
  assign pick1    = head_valid[1] &
                    (~head_valid[0] | (age_of(head[1], rob_head) < age_of(head[0], rob_head)));
  assign pop[0]   = load & head_valid[0] & ~pick1;
  assign pop[1]   = load & pick1;
  assign kill_out = age_of(out_data, rob_head) > flush_age;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < 2; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
      end
    end else if (flush_all) begin
      for (int p = 0; p < 2; p++) begin
        wr_ptr[p] <= '0;
        rd_ptr[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        wr_ptr[p] <= base_wr[p] + PW'(we[p]);
        rd_ptr[p] <= rd_ptr[p] + PW'(pop[p]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (we[p]) mem[p][base_wr[p][AW-1:0]] <= in_data[p];
    end
  end

  // On a partial flush the output entry leaves if it is killed or if its handshake completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (flush_all) begin
      out_valid <= 1'b0;
    end else if (partial) begin
      if (out_valid && (kill_out || out_ready)) out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= head_valid[0] | head_valid[1];
      if (head_valid[0] | head_valid[1]) out_data <= pick1 ? head[1] : head[0];
    end
  end

  a_in0_protocol: assert property (@(posedge clk) disable iff (!rst_n) !(in0_valid && !in0_ready));
  a_in1_protocol: assert property (@(posedge clk) disable iff (!rst_n) !(in1_valid && !in1_ready));

endmodule

// File: tb/tb_bru_update_arbiter.sv
// Bench for bru_update_arbiter: queue-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_bru_update_arbiter;
  localparam int DEPTH = 2;
  localparam int TW    = 5;
  localparam int IW    = 8;
  localparam int UW    = IW + TW + 1;

  typedef struct {
    logic [UW-1:0] d;
    int            abs;
  } ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in0_valid = 1'b0;
  logic [UW-1:0] in0_data = '0;
  logic          in0_ready;
  logic          in1_valid = 1'b0;
  logic [UW-1:0] in1_data = '0;
  logic          in1_ready;
  logic [TW-1:0] rob_head = '0;
  logic          flush_valid = 1'b0;
  logic [TW-1:0] flush_ticket = '0;
  logic          flush_all = 1'b0;
  logic          out_valid;
  logic [UW-1:0] out_data;
  logic          out_ready = 1'b0;

  int   abs_in [2];
  ent_t q [2][$];
  ent_t oreg;
  bit   ov;
  int   checks = 0;
  int   errors = 0;
  int   nxt;

  bru_update_arbiter #(.DEPTH(DEPTH), .TICKET_W(TW), .INFO_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .rob_head(rob_head), .flush_valid(flush_valid), .flush_ticket(flush_ticket),
    .flush_all(flush_all), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic int age(logic [TW-1:0] t);
    logic [TW-1:0] a;
    a = t - rob_head;
    return int'(a);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic clear_model();
    q[0].delete();
    q[1].delete();
    ov = 0;
  endtask

  task automatic idle();
    in0_valid   = 1'b0;
    in1_valid   = 1'b0;
    flush_valid = 1'b0;
    flush_all   = 1'b0;
  endtask

  task automatic drive(int p, bit vj, int abs);
    logic [TW-1:0] t;
    logic [IW-1:0] info;
    t = abs[TW-1:0];
    info = IW'($urandom);
    abs_in[p] = abs;
    if (p == 0) begin
      in0_valid = 1'b1;
      in0_data  = {vj, info, t};
    end else begin
      in1_valid = 1'b1;
      in1_data  = {vj, info, t};
    end
  endtask

  // Advance the model by one clock edge using the inputs applied for that edge.
  task automatic model_step();
    bit            rdy [2];
    bit            ival [2];
    logic [UW-1:0] idat [2];
    ent_t          keep [$];
    ent_t          e;
    int            fage;
    int            s;
    ival[0] = in0_valid;
    ival[1] = in1_valid;
    idat[0] = in0_data;
    idat[1] = in1_data;
    for (int p = 0; p < 2; p++) rdy[p] = (q[p].size() < DEPTH);
    if (flush_all) begin
      clear_model();
    end else if (flush_valid) begin
      fage = age(flush_ticket);
      for (int p = 0; p < 2; p++) begin
        keep = {};
        for (int i = 0; i < q[p].size(); i++)
          if (age(q[p][i].d[TW-1:0]) <= fage) keep.push_back(q[p][i]);
        q[p] = keep;
      end
      if (ov && (age(oreg.d[TW-1:0]) > fage || out_ready)) ov = 0;
      for (int p = 0; p < 2; p++) begin
        if (ival[p] && idat[p][UW-1] && rdy[p] && age(idat[p][TW-1:0]) <= fage) begin
          e.d = idat[p];
          e.abs = abs_in[p];
          q[p].push_back(e);
        end
      end
    end else begin
      if (!ov || out_ready) begin
        ov = 0;
        if (q[0].size() != 0 || q[1].size() != 0) begin
          s = 0;
          if (q[0].size() == 0) s = 1;
          else if (q[1].size() != 0 && age(q[1][0].d[TW-1:0]) < age(q[0][0].d[TW-1:0])) s = 1;
          oreg = q[s].pop_front();
          ov = 1;
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (ival[p] && idat[p][UW-1] && rdy[p]) begin
          e.d = idat[p];
          e.abs = abs_in[p];
          q[p].push_back(e);
        end
      end
    end
  endtask

  task automatic compare();
    chk("out_valid", {31'd0, out_valid}, {31'd0, ov});
    if (ov) chk("out_data", 32'(out_data), 32'(oreg.d));
    chk("in0_ready", {31'd0, in0_ready}, {31'd0, q[0].size() < DEPTH});
    chk("in1_ready", {31'd0, in1_ready}, {31'd0, q[1].size() < DEPTH});
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Called between a falling and the next rising edge; never spans a clock edge.
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in0_ready", {31'd0, in0_ready}, 32'd1);
    chk("rst_in1_ready", {31'd0, in1_ready}, 32'd1);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    @(negedge clk);

    // Single port, tickets 3 then 4.
    do_reset();
    rob_head = 0; out_ready = 1'b1;
    drive(0, 1, 3); tick();
    chk("sp_lat_e1", {31'd0, out_valid}, 32'd0);
    drive(0, 1, 4); tick(); idle();
    chk("sp_first_valid", {31'd0, out_valid}, 32'd1);
    chk("sp_first_ticket", 32'(out_data[TW-1:0]), 32'd3);
    tick();
    chk("sp_second_ticket", 32'(out_data[TW-1:0]), 32'd4);
    tick();
    chk("sp_drained", {31'd0, out_valid}, 32'd0);

    // Age arbitration across ticket wrap.
    do_reset();
    rob_head = 30; out_ready = 1'b1;
    drive(0, 1, 2); drive(1, 1, 31); tick(); idle();
    tick();
    chk("wrap_first", 32'(out_data[TW-1:0]), 32'd31);
    tick();
    chk("wrap_second", 32'(out_data[TW-1:0]), 32'd2);

    // Backpressure fills FIFO plus output register.
    do_reset();
    rob_head = 0; out_ready = 1'b0;
    drive(0, 1, 1); tick();
    drive(0, 1, 2); tick();
    drive(0, 1, 3); tick(); idle();
    chk("bp_full", {31'd0, in0_ready}, 32'd0);
    chk("bp_hold0", 32'(out_data[TW-1:0]), 32'd1);
    tick(); tick();
    chk("bp_hold2", 32'(out_data[TW-1:0]), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_out2", 32'(out_data[TW-1:0]), 32'd2);
    tick();
    chk("bp_out3", 32'(out_data[TW-1:0]), 32'd3);
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Partial flush at ticket 6.
    do_reset();
    rob_head = 0; out_ready = 1'b0;
    drive(0, 1, 4); drive(1, 1, 7); tick(); idle();
    drive(0, 1, 5); tick(); idle();
    drive(0, 1, 9); tick(); idle();
    chk("pf_pre_out", 32'(out_data[TW-1:0]), 32'd4);
    flush_valid = 1'b1; flush_ticket = 6;
    drive(1, 1, 8); tick(); idle();
    chk("pf_out_kept", {31'd0, out_valid}, 32'd1);
    chk("pf_out_ticket", 32'(out_data[TW-1:0]), 32'd4);
    chk("pf_in0_ready", {31'd0, in0_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("pf_survivor", 32'(out_data[TW-1:0]), 32'd5);
    tick();
    chk("pf_rest_gone", {31'd0, out_valid}, 32'd0);

    // valid_jump filter, then flush_all with a full FIFO.
    do_reset();
    rob_head = 0; out_ready = 1'b1;
    drive(0, 0, 1); tick(); idle();
    tick(); tick();
    chk("vj_dropped", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    drive(0, 1, 2); drive(1, 1, 5); tick(); idle();
    drive(0, 1, 3); tick(); idle();
    drive(0, 1, 4); tick(); idle();
    chk("fa_pre_full", {31'd0, in0_ready}, 32'd0);
    flush_all = 1'b1;
    drive(1, 1, 7); tick(); idle();
    chk("fa_out_valid", {31'd0, out_valid}, 32'd0);
    chk("fa_in0_ready", {31'd0, in0_ready}, 32'd1);
    chk("fa_in1_ready", {31'd0, in1_ready}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("fa_input_dropped", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-stream.
    do_reset();
    rob_head = 0; out_ready = 1'b0;
    drive(0, 1, 1); tick();
    drive(0, 1, 2); tick(); idle();
    chk("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_async_valid", {31'd0, out_valid}, 32'd0);
    clear_model();
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick(); tick();
    chk("ar_fifo_empty", {31'd0, out_valid}, 32'd0);

    // Randomized traffic with flushes and stalls.
    do_reset();
    nxt = 25;
    for (int c = 0; c < 3000; c++) begin
      int lo;
      int rh_abs;
      int ft_abs;
      bit fa;
      bit fv;
      int first;
      int p;
      lo = nxt;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < q[k].size(); i++)
          if (q[k][i].abs < lo) lo = q[k][i].abs;
      if (ov && oreg.abs < lo) lo = oreg.abs;
      rh_abs = lo - int'($urandom_range(0, 3));
      rob_head = rh_abs[TW-1:0];
      fa = ($urandom_range(0, 63) == 0);
      fv = ($urandom_range(0, 15) == 0);
      ft_abs = (nxt > rh_abs) ? int'($urandom_range(nxt - 1, rh_abs)) : rh_abs;
      flush_all    = fa;
      flush_valid  = fv;
      flush_ticket = ft_abs[TW-1:0];
      out_ready    = ($urandom_range(0, 3) != 0);
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      first = int'($urandom_range(0, 1));
      for (int k = 0; k < 2; k++) begin
        p = first ^ k;
        if (q[p].size() < DEPTH && (nxt - lo) < 20 && $urandom_range(0, 2) != 0) begin
          drive(p, $urandom_range(0, 7) != 0, nxt);
          nxt++;
        end
      end
      tick();
      if (fv && !fa) nxt = ft_abs + 1;
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
